nv_nvdla_mcif_rd_wrr_arb: RTL

// - Weighted round-robin read-request arbiter for MCIF; consumes rd_weight_* and rd_os_cnt from MCIF CSB reg block.
// - Merges NUM_CLIENTS client read-request streams into one stream toward the NOC read path.
// - Caps outstanding read requests at rd_os_cnt; returns tracked via rd_rsp_done pulses.

---
 rtl/nv_nvdla_mcif_rd_wrr_arb_if.sv | 43 ++++
 rtl/nv_nvdla_mcif_rd_wrr_arb.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/nv_nvdla_mcif_rd_wrr_arb_if.sv
//----------------------------------------------------------------------------
// Module  : nv_nvdla_mcif_rd_wrr_arb_if
// Brief   : Client request and downstream request bundle for the MCIF read arbiter.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

interface nv_nvdla_mcif_rd_wrr_arb_if #(
    parameter int NUM_CLIENTS = 4,
    parameter int PLD_W       = 79
);
    logic [NUM_CLIENTS-1:0]       cli_req_valid;
    logic [NUM_CLIENTS-1:0]       cli_req_ready;
    logic [NUM_CLIENTS*PLD_W-1:0] cli_req_pd;
    logic                         arb_req_valid;
    logic                         arb_req_ready;
    logic [PLD_W-1:0]             arb_req_pd;
    logic [2:0]                   arb_req_id;

    // Arbiter side
    modport master (
        input  cli_req_valid,
        input  cli_req_pd,
        input  arb_req_ready,
        output cli_req_ready,
        output arb_req_valid,
        output arb_req_pd,
        output arb_req_id
    );

    // Client / downstream side
    modport slave (
        output cli_req_valid,
        output cli_req_pd,
        output arb_req_ready,
        input  cli_req_ready,
        input  arb_req_valid,
        input  arb_req_pd,
        input  arb_req_id
    );
endinterface

`default_nettype wire

// File: rtl/nv_nvdla_mcif_rd_wrr_arb.sv
//----------------------------------------------------------------------------
// Module  : nv_nvdla_mcif_rd_wrr_arb
// Brief   : Weighted round-robin MCIF read-request arbiter with outstanding cap.
//           Optional macro NVDLA_MCIF_RD_ARB_PERF_EN adds perf_stall_cnt.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module nv_nvdla_mcif_rd_wrr_arb #(
    parameter int NUM_CLIENTS = 4,
    parameter int PLD_W       = 79
) (
    input  logic                     nvdla_core_clk,
    input  logic                     nvdla_core_rstn,
    nv_nvdla_mcif_rd_wrr_arb_if.master bus,
    input  logic [NUM_CLIENTS*8-1:0] cli_weight,
    input  logic [7:0]               rd_os_cnt,
    input  logic                     rd_rsp_done,
    output logic [8:0]               os_cnt_cur,
    output logic                     os_err
`ifdef NVDLA_MCIF_RD_ARB_PERF_EN
    ,
    output logic [31:0]              perf_stall_cnt
`endif
);

    localparam logic [8:0] c_os_max = 9'd256;

    logic [7:0]             r_credit [NUM_CLIENTS];
    logic [2:0]             r_rr;
    logic [NUM_CLIENTS-1:0] w_elig;
    logic [NUM_CLIENTS-1:0] w_elig_rot;
    logic                   w_any_valid;
    logic                   w_slot_free;
    logic                   w_os_ok;
    logic                   w_reload;
    logic                   w_pick_vld;
    logic                   w_grant;
    logic [2:0]             w_gnt_idx;
    logic [7:0]             w_gnt_credit;
    logic [PLD_W-1:0]       w_gnt_pd;

    function automatic logic [2:0] wrap_add(input logic [2:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_CLIENTS) begin
            sum = sum - NUM_CLIENTS;
        end
        return sum[2:0];
    endfunction

    generate
        for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_elig
            assign w_elig[i] = bus.cli_req_valid[i] && (r_credit[i] != 8'd0);
        end
    endgenerate

    assign w_any_valid = |bus.cli_req_valid;
    assign w_slot_free = !bus.arb_req_valid || bus.arb_req_ready;
    assign w_os_ok     = os_cnt_cur < {1'b0, rd_os_cnt};
    assign w_reload    = w_slot_free && w_any_valid && !(|w_elig);
    assign w_grant     = w_slot_free && w_os_ok && w_pick_vld;

    // Rotate so bit 0 is the client under the rr pointer; lowest set bit wins.
    assign w_elig_rot = NUM_CLIENTS'({w_elig, w_elig} >> r_rr);

    always_comb begin
        w_pick_vld = 1'b0;
        w_gnt_idx  = 3'd0;
        for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
            if (w_elig_rot[k]) begin
                w_pick_vld = 1'b1;
                w_gnt_idx  = wrap_add(r_rr, k);
            end
        end
    end

    always_comb begin
        w_gnt_pd          = '0;
        w_gnt_credit      = 8'd0;
        bus.cli_req_ready = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (w_gnt_idx == 3'(i)) begin
                w_gnt_pd             = bus.cli_req_pd[i*PLD_W +: PLD_W];
                w_gnt_credit         = r_credit[i];
                bus.cli_req_ready[i] = w_grant;
            end
        end
    end

    // Weights are only looked at on reload, so CSB updates land on the next round.
    generate
        for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_credit
            always_ff @(posedge nvdla_core_clk) begin
                if (!nvdla_core_rstn) begin
                    r_credit[i] <= 8'd0;
                end else if (w_reload) begin
                    r_credit[i] <= (cli_weight[i*8 +: 8] == 8'd0) ? 8'd1 : cli_weight[i*8 +: 8];
                end else if (w_grant && (w_gnt_idx == 3'(i))) begin
                    r_credit[i] <= r_credit[i] - 8'd1;
                end
            end
        end
    endgenerate

    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            r_rr <= 3'd0;
        end else if (w_grant) begin
            // Stay on the winner while it still holds credit after this grant.
            r_rr <= (w_gnt_credit > 8'd1) ? w_gnt_idx : wrap_add(w_gnt_idx, 1);
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            bus.arb_req_valid <= 1'b0;
            bus.arb_req_pd    <= '0;
            bus.arb_req_id    <= 3'd0;
        end else if (w_slot_free) begin
            bus.arb_req_valid <= w_grant;
            if (w_grant) begin
                bus.arb_req_pd <= w_gnt_pd;
                bus.arb_req_id <= w_gnt_idx;
            end
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            os_cnt_cur <= 9'd0;
            os_err     <= 1'b0;
        end else if (w_grant && !rd_rsp_done) begin
            if (os_cnt_cur != c_os_max) begin
                os_cnt_cur <= os_cnt_cur + 9'd1;
            end
        end else if (!w_grant && rd_rsp_done) begin
            if (os_cnt_cur == 9'd0) begin
                os_err <= 1'b1;
            end else begin
                os_cnt_cur <= os_cnt_cur - 9'd1;
            end
        end
    end

`ifdef NVDLA_MCIF_RD_ARB_PERF_EN
    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            perf_stall_cnt <= 32'd0;
        end else if (w_any_valid && !w_os_ok && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

`default_nettype wire
